// File: rtl/tlb_mp.sv
// tlb_mp: joint MIPS TLB with NUM_PORTS independent lookup channels, one CP0
// maintenance port (TLBR/TLBWI/TLBWR/TLBP) and a hardware Random register.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   op_valid, op, op_done        maintenance op request / one-cycle completion
//   index_i, wired_i, wired_we   CP0 Index and Wired registers
//   mask_i, entryhi_i,
//   entrylo0_i, entrylo1_i       CP0 PageMask[24:13], EntryHi, EntryLo0/1
//   rd_*_o                       TLBR read-back (held until the next TLBR)
//   probe_index_o                TLBP result (bit 31 = miss)
//   random_o                     Random register
//   kernel_mode, cp0_erl,
//   kseg0_cached                 privilege / segment-mapping controls
//   lk_req, lk_va                per-port lookup request, port p at [32p+31:32p]
//   lk_valid, lk_pa, lk_hit,
//   lk_v, lk_d, lk_cached,
//   lk_error                     per-port registered lookup results
//   multi_hit_o                  probe or lookup matched more than one entry
module tlb_mp #(
  parameter int TLB_NUM   = 32,
  parameter int IDX_BITS  = $clog2(TLB_NUM),
  parameter int NUM_PORTS = 2,
  parameter int ASID_BITS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      op_valid,
  input  logic [1:0]                op,
  output logic                      op_done,
  input  logic [IDX_BITS-1:0]       index_i,
  input  logic [IDX_BITS-1:0]       wired_i,
  input  logic                      wired_we,
  input  logic [11:0]               mask_i,
  input  logic [31:0]               entryhi_i,
  input  logic [31:0]               entrylo0_i,
  input  logic [31:0]               entrylo1_i,
  output logic [11:0]               rd_mask_o,
  output logic [31:0]               rd_entryhi_o,
  output logic [31:0]               rd_entrylo0_o,
  output logic [31:0]               rd_entrylo1_o,
  output logic [31:0]               probe_index_o,
  output logic [IDX_BITS-1:0]       random_o,
  input  logic                      kernel_mode,
  input  logic                      cp0_erl,
  input  logic                      kseg0_cached,
  input  logic [NUM_PORTS-1:0]      lk_req,
  input  logic [32*NUM_PORTS-1:0]   lk_va,
  output logic [NUM_PORTS-1:0]      lk_valid,
  output logic [32*NUM_PORTS-1:0]   lk_pa,
  output logic [NUM_PORTS-1:0]      lk_hit,
  output logic [NUM_PORTS-1:0]      lk_v,
  output logic [NUM_PORTS-1:0]      lk_d,
  output logic [NUM_PORTS-1:0]      lk_cached,
  output logic [NUM_PORTS-1:0]      lk_error,
  output logic                      multi_hit_o
);

  localparam logic [1:0] OP_TLBR  = 2'b00;
  localparam logic [1:0] OP_TLBWI = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b10;
  localparam logic [1:0] OP_TLBP  = 2'b11;
  localparam logic [IDX_BITS-1:0] RAND_TOP = IDX_BITS'(TLB_NUM - 1);

  // Entry storage; pfn values are kept pre-masked so a PA is a plain OR.
  logic [11:0]          e_mask [TLB_NUM];
  logic [18:0]          e_vpn2 [TLB_NUM];
  logic [ASID_BITS-1:0] e_asid [TLB_NUM];
  logic                 e_g    [TLB_NUM];
  logic [19:0]          e_pfn0 [TLB_NUM];
  logic [19:0]          e_pfn1 [TLB_NUM];
  logic [2:0]           e_c0   [TLB_NUM];
  logic [2:0]           e_c1   [TLB_NUM];
  logic                 e_d0   [TLB_NUM];
  logic                 e_d1   [TLB_NUM];
  logic                 e_v0   [TLB_NUM];
  logic                 e_v1   [TLB_NUM];

  logic [ASID_BITS-1:0] cur_asid;
  logic                 do_write, do_read, do_probe;
  logic [IDX_BITS-1:0]  wr_idx;
  logic                 unused_bits;

  assign cur_asid    = entryhi_i[ASID_BITS-1:0];
  assign do_read     = op_valid && (op == OP_TLBR);
  assign do_probe    = op_valid && (op == OP_TLBP);
  assign do_write    = op_valid && ((op == OP_TLBWI) || (op == OP_TLBWR));
  assign wr_idx      = (op == OP_TLBWR) ? random_o : index_i;
  assign unused_bits = ^{entryhi_i[12:0], entrylo0_i[31:26], entrylo1_i[31:26]};

  function automatic logic [3:0] popcnt(input logic [11:0] m);
    popcnt = '0;
    for (int b = 0; b < 12; b++) popcnt = popcnt + 4'(m[b]);
  endfunction

  // Lowest-index priority encoder; multi flags a second set bit.
  function automatic void prio(input logic [TLB_NUM-1:0] v, output logic [IDX_BITS-1:0] idx,
                               output logic found, output logic multi);
    idx   = '0;
    found = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < TLB_NUM; i++) begin
      if (v[i]) begin
        if (found) multi = 1'b1;
        else begin
          found = 1'b1;
          idx   = IDX_BITS'(i);
        end
      end
    end
  endfunction

  // Match vectors for the probe (EntryHi) and every lookup port (its VA);
  // both compare against current contents, so same-cycle writes are unseen.
  logic [TLB_NUM-1:0] probe_hits;
  logic [TLB_NUM-1:0] lk_hits [NUM_PORTS];

  always_comb begin
    probe_hits = '0;
    for (int i = 0; i < TLB_NUM; i++) begin
      probe_hits[i] = (((entryhi_i[31:13] ^ e_vpn2[i]) & ~{7'b0, e_mask[i]}) == 19'd0) &&
                      (e_g[i] || (e_asid[i] == cur_asid));
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      lk_hits[p] = '0;
      for (int i = 0; i < TLB_NUM; i++) begin
        lk_hits[p][i] = (((lk_va[32*p+13 +: 19] ^ e_vpn2[i]) & ~{7'b0, e_mask[i]}) == 19'd0) &&
                        (e_g[i] || (e_asid[i] == cur_asid));
      end
    end
  end

  logic [IDX_BITS-1:0] probe_idx;
  logic                probe_found, probe_multi;
  logic [31:0]         probe_c, rd_hi_c;

  always_comb begin
    prio(probe_hits, probe_idx, probe_found, probe_multi);
    probe_c = '0;
    probe_c[31] = ~probe_found;
    probe_c[IDX_BITS-1:0] = probe_idx;
    rd_hi_c = '0;
    rd_hi_c[31:13] = e_vpn2[index_i];
    rd_hi_c[ASID_BITS-1:0] = e_asid[index_i];
  end

  // Per-port segment decode and result formation. Error results are forced
  // to zeros so no X leaks out of a faulting access.
  logic [31:0]          n_pa [NUM_PORTS];
  logic [NUM_PORTS-1:0] n_hit, n_v, n_d, n_cached, n_error, n_multi;

  always_comb begin
    logic [31:0]         va;
    logic [IDX_BITS-1:0] idx;
    logic                found, multi, mapped, unmapped, odd;
    logic [4:0]          sel_pos;
    for (int p = 0; p < NUM_PORTS; p++) begin
      va       = lk_va[32*p +: 32];
      prio(lk_hits[p], idx, found, multi);
      mapped   = 1'b0;
      unmapped = 1'b0;
      n_pa[p]     = '0;
      n_hit[p]    = 1'b0;
      n_v[p]      = 1'b0;
      n_d[p]      = 1'b0;
      n_cached[p] = 1'b0;
      n_error[p]  = 1'b0;
      case (va[31:29])
        3'b100, 3'b101: if (kernel_mode) unmapped = 1'b1; else n_error[p] = 1'b1;
        3'b110:         n_error[p] = 1'b1;
        3'b111:         if (kernel_mode) mapped = 1'b1; else n_error[p] = 1'b1;
        default:        if (kernel_mode && cp0_erl) unmapped = 1'b1; else mapped = 1'b1;
      endcase
      // The even/odd select is the first VA bit above the page-offset field.
      sel_pos = 5'd12 + 5'(popcnt(e_mask[idx]));
      odd     = va[sel_pos];
      if (unmapped) begin
        n_pa[p]     = {3'b000, va[28:0]};
        n_hit[p]    = 1'b1;
        n_v[p]      = 1'b1;
        n_d[p]      = 1'b1;
        n_cached[p] = (va[31:29] == 3'b100) && kseg0_cached;
      end else if (mapped && found) begin
        n_pa[p]     = {(odd ? e_pfn1[idx] : e_pfn0[idx]), 12'h000} |
                      (va & {8'h00, e_mask[idx], 12'hfff});
        n_hit[p]    = 1'b1;
        n_v[p]      = odd ? e_v1[idx] : e_v0[idx];
        n_d[p]      = odd ? e_d1[idx] : e_d0[idx];
        n_cached[p] = (odd ? e_c1[idx] : e_c0[idx]) == 3'd3;
      end
      n_multi[p] = mapped && multi;
    end
  end

  // Entry array: cleared to invalid, coherent-cached (C=3) entries on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TLB_NUM; i++) begin
        e_mask[i] <= '0; e_vpn2[i] <= '0; e_asid[i] <= '0; e_g[i] <= 1'b0;
        e_pfn0[i] <= '0; e_pfn1[i] <= '0; e_c0[i] <= 3'd3; e_c1[i] <= 3'd3;
        e_d0[i] <= 1'b0; e_d1[i] <= 1'b0; e_v0[i] <= 1'b0; e_v1[i] <= 1'b0;
      end
    end else if (do_write) begin
      e_mask[wr_idx] <= mask_i;
      e_vpn2[wr_idx] <= entryhi_i[31:13] & ~{7'b0, mask_i};
      e_asid[wr_idx] <= cur_asid;
      e_g[wr_idx]    <= entrylo0_i[0] & entrylo1_i[0];
      e_pfn0[wr_idx] <= entrylo0_i[25:6] & ~{8'b0, mask_i};
      e_pfn1[wr_idx] <= entrylo1_i[25:6] & ~{8'b0, mask_i};
      e_c0[wr_idx]   <= entrylo0_i[5:3];
      e_c1[wr_idx]   <= entrylo1_i[5:3];
      e_d0[wr_idx]   <= entrylo0_i[2];
      e_d1[wr_idx]   <= entrylo1_i[2];
      e_v0[wr_idx]   <= entrylo0_i[1];
      e_v1[wr_idx]   <= entrylo1_i[1];
    end
  end

  // Random counts down through the non-wired slots and wraps to the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) random_o <= RAND_TOP;
    else if (wired_we || (random_o <= wired_i) || (random_o == '0)) random_o <= RAND_TOP;
    else random_o <= random_o - IDX_BITS'(1);
  end

  // Maintenance results; TLBR and TLBP outputs hold between their own ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_done       <= 1'b0;
      rd_mask_o     <= '0;
      rd_entryhi_o  <= '0;
      rd_entrylo0_o <= '0;
      rd_entrylo1_o <= '0;
      probe_index_o <= '0;
      multi_hit_o   <= 1'b0;
    end else begin
      op_done     <= op_valid;
      multi_hit_o <= (do_probe && probe_multi) || (|(lk_req & n_multi));
      if (do_read) begin
        rd_mask_o     <= e_mask[index_i];
        rd_entryhi_o  <= rd_hi_c;
        rd_entrylo0_o <= {6'b0, e_pfn0[index_i], e_c0[index_i], e_d0[index_i], e_v0[index_i], e_g[index_i]};
        rd_entrylo1_o <= {6'b0, e_pfn1[index_i], e_c1[index_i], e_d1[index_i], e_v1[index_i], e_g[index_i]};
      end
      if (do_probe) probe_index_o <= probe_c;
    end
  end

  // Lookup pipeline register; result fields only move when a port requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_valid  <= '0;
      lk_pa     <= '0;
      lk_hit    <= '0;
      lk_v      <= '0;
      lk_d      <= '0;
      lk_cached <= '0;
      lk_error  <= '0;
    end else begin
      lk_valid <= lk_req;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (lk_req[p]) begin
          lk_pa[32*p +: 32] <= n_pa[p];
          lk_hit[p]         <= n_hit[p];
          lk_v[p]           <= n_v[p];
          lk_d[p]           <= n_d[p];
          lk_cached[p]      <= n_cached[p];
          lk_error[p]       <= n_error[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_tlb_mp.sv
// tb_tlb_mp: directed, table-driven bench for tlb_mp (32 entries, 2 ports).
// Expected values are hand-computed from the entry encodings written below.
module tb_tlb_mp;

  logic        clk, rst_n, op_valid, op_done, wired_we;
  logic [1:0]  op;
  logic [4:0]  index_i, wired_i, random_o;
  logic [11:0] mask_i, rd_mask_o;
  logic [31:0] entryhi_i, entrylo0_i, entrylo1_i;
  logic [31:0] rd_entryhi_o, rd_entrylo0_o, rd_entrylo1_o, probe_index_o;
  logic        kernel_mode, cp0_erl, kseg0_cached, multi_hit_o;
  logic [1:0]  lk_req, lk_valid, lk_hit, lk_v, lk_d, lk_cached, lk_error;
  logic [63:0] lk_va, lk_pa;

  int vectors = 0;
  int miscompares = 0;

  tlb_mp #(.TLB_NUM(32), .NUM_PORTS(2), .ASID_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .op_done(op_done),
    .index_i(index_i), .wired_i(wired_i), .wired_we(wired_we), .mask_i(mask_i),
    .entryhi_i(entryhi_i), .entrylo0_i(entrylo0_i), .entrylo1_i(entrylo1_i),
    .rd_mask_o(rd_mask_o), .rd_entryhi_o(rd_entryhi_o), .rd_entrylo0_o(rd_entrylo0_o),
    .rd_entrylo1_o(rd_entrylo1_o), .probe_index_o(probe_index_o), .random_o(random_o),
    .kernel_mode(kernel_mode), .cp0_erl(cp0_erl), .kseg0_cached(kseg0_cached),
    .lk_req(lk_req), .lk_va(lk_va), .lk_valid(lk_valid), .lk_pa(lk_pa), .lk_hit(lk_hit),
    .lk_v(lk_v), .lk_d(lk_d), .lk_cached(lk_cached), .lk_error(lk_error),
    .multi_hit_o(multi_hit_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One lookup vector: inputs, then PA and flags {valid,hit,v,d,cached,error}.
  typedef struct {
    logic        kernel;
    logic        erl;
    logic        k0c;
    logic [7:0]  asid;
    logic [31:0] va;
    logic [31:0] pa;
    logic [5:0]  flags;
  } lk_vec_t;

  lk_vec_t vecs[14];
  logic [4:0] rand_seq [10] = '{5'd31, 5'd30, 5'd29, 5'd28, 5'd31, 5'd30, 5'd29, 5'd28, 5'd31, 5'd30};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input lk_vec_t v);
    op_valid     = 1'b0;
    kernel_mode  = v.kernel;
    cp0_erl      = v.erl;
    kseg0_cached = v.k0c;
    entryhi_i    = {24'h0, v.asid};
    lk_req       = 2'b11;
    lk_va        = {v.va, v.va};
  endtask

  task automatic issueOp(input logic [1:0] o, input logic [4:0] idx, input logic [11:0] m,
                         input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
    op_valid = 1'b1; op = o; index_i = idx; mask_i = m;
    entryhi_i = hi; entrylo0_i = lo0; entrylo1_i = lo1;
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op = 2'b00; index_i = '0; wired_i = '0; wired_we = 1'b0;
    mask_i = '0; entryhi_i = '0; entrylo0_i = '0; entrylo1_i = '0;
    kernel_mode = 1'b0; cp0_erl = 1'b0; kseg0_cached = 1'b0; lk_req = '0; lk_va = '0;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h8000_0000, 32'h0000_0000, 6'b100001};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'h00, 32'h8000_1234, 32'h0000_1234, 6'b111110};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'h00, 32'hA000_1234, 32'h0000_1234, 6'b111100};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 32'h0000_1000, 32'h0000_1000, 6'b111100};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 32'hC000_0000, 32'h0000_0000, 6'b100001};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 32'hC000_0000, 32'h0000_0000, 6'b100001};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 32'hE000_0000, 32'h0000_0000, 6'b100001};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 32'hE000_0000, 32'h0000_0000, 6'b100000};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 32'h0040_2ABC, 32'h0011_1ABC, 6'b111010};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h0040_3ABC, 32'h0022_2ABC, 6'b111110};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h1234_7ABC, 32'h0000_0000, 6'b100000};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 32'h9FFF_FFFF, 32'h1FFF_FFFF, 6'b111100};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h7FFF_F000, 32'h0000_0000, 6'b100000};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h05, 32'h1234_7ABC, 32'h0012_3ABC, 6'b111110};

    // Reset state, then TLBR of an untouched entry.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("rst_random", 32'(random_o), 32'd31);
    checkOutput("rst_op_done", 32'(op_done), 32'd0);
    checkOutput("rst_lk_valid", 32'(lk_valid), 32'd0);
    checkOutput("rst_probe", probe_index_o, 32'd0);
    issueOp(2'b00, 5'd5, 12'h0, 32'h0, 32'h0, 32'h0);
    step();
    checkOutput("tlbr5_lo0", rd_entrylo0_o, 32'h0000_0018);
    checkOutput("tlbr5_hi", rd_entryhi_o, 32'h0);
    checkOutput("tlbr5_done", 32'(op_done), 32'd1);
    checkOutput("random_30", 32'(random_o), 32'd30);
    op_valid = 1'b0;
    step();
    checkOutput("random_29", 32'(random_o), 32'd29);
    checkOutput("done_clear", 32'(op_done), 32'd0);

    // TLBWI entry 3: even pfn 0x40 C=2 D V, odd pfn 0x80 C=3 D V, global.
    issueOp(2'b01, 5'd3, 12'h0, 32'h0040_2001, 32'h0000_1017, 32'h0000_201F);
    step();
    op_valid = 1'b0;
    lk_req = 2'b11;
    lk_va = {32'h0040_3ABC, 32'h0040_2ABC};
    step();
    checkOutput("wi3_p0_pa", lk_pa[31:0], 32'h0004_0ABC);
    checkOutput("wi3_p0_flags", {26'b0, lk_valid[0], lk_hit[0], lk_v[0], lk_d[0], lk_cached[0], lk_error[0]}, 32'b111100);
    checkOutput("wi3_p1_pa", lk_pa[63:32], 32'h0008_0ABC);
    checkOutput("wi3_p1_flags", {26'b0, lk_valid[1], lk_hit[1], lk_v[1], lk_d[1], lk_cached[1], lk_error[1]}, 32'b111110);
    checkOutput("wi3_multi", 32'(multi_hit_o), 32'd0);
    lk_req = 2'b00;
    lk_va = {32'hC000_0000, 32'hC000_0000};
    issueOp(2'b00, 5'd3, 12'h0, 32'h0, 32'h0, 32'h0);
    step();
    op_valid = 1'b0;
    checkOutput("hold_valid", 32'(lk_valid), 32'd0);
    checkOutput("hold_p0_pa", lk_pa[31:0], 32'h0004_0ABC);
    checkOutput("tlbr3_hi", rd_entryhi_o, 32'h0040_2001);
    checkOutput("tlbr3_lo0", rd_entrylo0_o, 32'h0000_1017);
    checkOutput("tlbr3_lo1", rd_entrylo1_o, 32'h0000_201F);

    // Random with Wired=28, then TLBWR of a 16KB page into the current slot.
    wired_i = 5'd28;
    wired_we = 1'b1;
    step();
    wired_we = 1'b0;
    checkOutput("rand_seq0", 32'(random_o), 32'(rand_seq[0]));
    for (int k = 1; k < 10; k++) begin
      step();
      checkOutput($sformatf("rand_seq%0d", k), 32'(random_o), 32'(rand_seq[k]));
    end
    issueOp(2'b10, 5'd0, 12'h003, 32'h1234_6005, 32'h0000_48DF, 32'h0000_48DE);
    step();
    checkOutput("wr_done", 32'(op_done), 32'd1);
    checkOutput("wr_random", 32'(random_o), 32'd29);
    issueOp(2'b00, 5'd30, 12'h0, 32'h0, 32'h0, 32'h0);
    step();
    checkOutput("tlbr30_mask", 32'(rd_mask_o), 32'h003);
    checkOutput("tlbr30_hi", rd_entryhi_o, 32'h1234_0005);
    checkOutput("tlbr30_lo0", rd_entrylo0_o, 32'h0000_481E);
    checkOutput("tlbr30_lo1", rd_entrylo1_o, 32'h0000_481E);
    index_i = 5'd29;
    step();
    checkOutput("tlbr29_lo0", rd_entrylo0_o, 32'h0000_0018);
    op_valid = 1'b0;
    wired_i = 5'd31;
    step();
    step();
    checkOutput("rand_wired_max", 32'(random_o), 32'd31);
    wired_i = 5'd0;

    // Entries 2 and 7 overlap entry 3's VPN2; back-to-back writes, then TLBP.
    issueOp(2'b01, 5'd2, 12'h0, 32'h0040_2000, 32'h0000_445B, 32'h0000_889F);
    step();
    issueOp(2'b01, 5'd7, 12'h0, 32'h0040_2000, 32'h0000_CCDB, 32'h0000_CCDB);
    step();
    checkOutput("b2b_done", 32'(op_done), 32'd1);
    issueOp(2'b11, 5'd0, 12'h0, 32'h0040_2000, 32'h0, 32'h0);
    step();
    checkOutput("probe_hit", probe_index_o, 32'd2);
    checkOutput("probe_multi", 32'(multi_hit_o), 32'd1);
    entryhi_i = 32'h7FFF_0000;
    step();
    checkOutput("probe_miss", probe_index_o, 32'h8000_0000);
    checkOutput("probe_miss_multi", 32'(multi_hit_o), 32'd0);
    op_valid = 1'b0;

    // Segment decode and mapped lookups from the table, on both ports.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      step();
      for (int p = 0; p < 2; p++) begin
        checkOutput($sformatf("vec%0d_p%0d_pa", i, p), lk_pa[32*p +: 32], vecs[i].pa);
        checkOutput($sformatf("vec%0d_p%0d_flags", i, p),
                    {26'b0, lk_valid[p], lk_hit[p], lk_v[p], lk_d[p], lk_cached[p], lk_error[p]},
                    {26'b0, vecs[i].flags});
      end
    end
    lk_req = 2'b01;
    kernel_mode = 1'b0;
    entryhi_i = 32'h0;
    lk_va = {32'h0, 32'h0040_2ABC};
    step();
    checkOutput("lk_multi", 32'(multi_hit_o), 32'd1);
    entryhi_i = 32'h5;
    lk_va = {32'h0, 32'h1234_7ABC};
    step();
    checkOutput("lk_single", 32'(multi_hit_o), 32'd0);

    // Write and lookup in the same cycle see the old contents.
    entryhi_i = 32'h0;
    lk_va = {32'h0, 32'h0050_0ABC};
    issueOp(2'b01, 5'd10, 12'h0, 32'h0050_0000, 32'h0000_2ADF, 32'h0000_2ADF);
    step();
    op_valid = 1'b0;
    checkOutput("same_cyc_hit", 32'(lk_hit[0]), 32'd0);
    checkOutput("same_cyc_pa", lk_pa[31:0], 32'h0);
    step();
    checkOutput("next_cyc_pa", lk_pa[31:0], 32'h000A_BABC);
    checkOutput("next_cyc_valid", 32'(lk_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(lk_valid), 32'd0);
    checkOutput("async_rst_pa", lk_pa[31:0], 32'h0);
    checkOutput("async_rst_random", 32'(random_o), 32'd31);
    lk_req = 2'b00;
    step();
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
